// File: rtl/fft_seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_seq_pkg : shared state encoding, counter width and saturating increment
// Revision    : 1.0
// ---------------------------------------------------------------------------
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : W-bit counter with increment and clear that sticks at all-ones
// Revision    : 1.0
// ---------------------------------------------------------------------------
module sat_counter
    import fft_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_inc;

    generate
        if (W == CNT_W) begin : g_pkg_inc
            assign count_inc = sat_inc(count_q);
        end else begin : g_gen_inc
            assign count_inc = (count_q == {W{1'b1}}) ? count_q : count_q + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_inc;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_frame_sequencer : frames a sample stream into BATCH_SIZE packets, one
// frame in flight until the peak results end. Optional FFT_SEQ_TIMEOUT_EN.
// Revision            : 1.0
// ---------------------------------------------------------------------------
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int BATCH_SIZE     = 1024,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    input  logic                  res_valid,
    input  logic                  res_eop,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  timeout_err
);

    localparam int            PW       = $clog2(BATCH_SIZE);
    localparam logic [PW-1:0] LAST_POS = PW'(BATCH_SIZE - 1);

    seq_state_t             state_q, state_d;
    logic [PW-1:0]          pos_q, pos_d;
    logic                   valid_q, valid_d;
    logic                   sop_q, sop_d;
    logic                   eop_q, eop_d;
    logic [DATA_WIDTH-1:0]  re_q, re_d;
    logic [DATA_WIDTH-1:0]  im_q, im_d;
    logic [CNT_W-1:0]       frame_q, frame_d;
    logic                   drop_inc;

`ifdef FFT_SEQ_TIMEOUT_EN
    localparam int            WW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wait_q;
    logic          terr_q, terr_d;
`else
    logic          unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        valid_d  = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        re_d     = re_q;
        im_d     = im_q;
        frame_d  = frame_q;
        drop_inc = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
        terr_d   = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && in_valid) begin
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    re_d    = in_re;
                    im_d    = in_im;
                    pos_d   = PW'(1);
                    state_d = FILL;
                end
            end
            FILL: begin
                // enable is only consulted at frame start; a started frame always completes
                if (in_valid) begin
                    valid_d = 1'b1;
                    re_d    = in_re;
                    im_d    = in_im;
                    if (pos_q == LAST_POS) begin
                        eop_d   = 1'b1;
                        pos_d   = '0;
                        state_d = WAIT;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                drop_inc = in_valid;
                if (res_valid && res_eop) begin
                    frame_d = frame_q + 1'b1;
                    state_d = IDLE;
                end
`ifdef FFT_SEQ_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            re_q    <= re_d;
            im_q    <= im_d;
            frame_q <= frame_d;
        end
    end

`ifdef FFT_SEQ_TIMEOUT_EN
    // Counter restarts at zero on every cycle outside WAIT, so it reads 0 on WAIT entry
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
            terr_q <= 1'b0;
        end else begin
            wait_q <= (state_q == WAIT) ? wait_q + 1'b1 : '0;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (drop_inc),
        .clr_i   (1'b0),
        .count_o (drop_cnt)
    );

    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign frame_cnt = frame_q;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
